// File: rtl/paddle_input_proc.sv
// Paddle input processor: once per frame, converts each player's stick, paddle
// or button input into a vertical paddle position (0 = top of screen).
// Latency: channel k settles 2+k cycles after the vblank rising edge; frame_strobe follows the last channel.
// Backpressure: none; vblank edges seen while a scan is in progress are dropped, not queued.
//
// Ports:
//   clk_sys        sole clock, all logic on its rising edge
//   reset          synchronous, active-high
//   vblank         vertical blank; a rising edge starts one scan of all channels
//   mode           3 bits per channel: 0 stick-Y, 1 stick-X, 2 inverted-X, 3 paddle, 4 digital (5-7 act as 0)
//   joy_analog     16 bits per channel, signed stick: [15:8] Y, [7:0] X
//   paddle         8 bits per channel, unsigned paddle
//   btn_up/down    one bit per channel, digital-mode buttons
//   pos            POS_W bits per channel, paddle position
//   frame_strobe   one-cycle pulse once every channel of the current scan is updated

module paddle_input_proc #(
  parameter int NUM_CH   = 2,
  parameter int POS_W    = 8,
  parameter int STEP_MAX = 4,
  parameter int HYST     = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    vblank,
  input  logic [3*NUM_CH-1:0]     mode,
  input  logic [16*NUM_CH-1:0]    joy_analog,
  input  logic [8*NUM_CH-1:0]     paddle,
  input  logic [NUM_CH-1:0]       btn_up,
  input  logic [NUM_CH-1:0]       btn_down,
  output logic [POS_W*NUM_CH-1:0] pos,
  output logic                    frame_strobe
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [3:0]       STEP_MAX_V = STEP_MAX[3:0];
  localparam logic [POS_W:0]   HYST_V     = HYST[POS_W:0];
  localparam logic [POS_W-1:0] POS_CTR    = {1'b1, {(POS_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_t           r_state;
  logic [CH_W-1:0]  r_ch;
  logic             r_vblank;
  logic             r_strobe;

  logic [POS_W-1:0] r_pos   [NUM_CH];
  logic [3:0]       r_speed [NUM_CH];

  // Per-frame snapshot of every input, so a scan never sees inputs that
  // change half way through the frame.
  logic [2:0]       r_mode_s [NUM_CH];
  logic [15:0]      r_joy_s  [NUM_CH];
  logic [7:0]       r_pad_s  [NUM_CH];
  logic             r_up_s   [NUM_CH];
  logic             r_dn_s   [NUM_CH];

  // ------------------------------------------------------------------
  // Currently scanned channel
  // ------------------------------------------------------------------
  logic             w_vb_rise;
  logic [2:0]       w_md;
  logic [15:0]      w_joy;
  logic [7:0]       w_pad;
  logic             w_up;
  logic             w_dn;
  logic [POS_W-1:0] w_cur;
  logic [3:0]       w_spd;

  assign w_vb_rise = vblank & ~r_vblank;
  assign w_md      = r_mode_s[r_ch];
  assign w_joy     = r_joy_s[r_ch];
  assign w_pad     = r_pad_s[r_ch];
  assign w_up      = r_up_s[r_ch];
  assign w_dn      = r_dn_s[r_ch];
  assign w_cur     = r_pos[r_ch];
  assign w_spd     = r_speed[r_ch];

  // ------------------------------------------------------------------
  // Analog path: raw 8-bit value, scaled to POS_W, then hysteresis.
  // Adding 0x80 to a signed axis maps -128..127 onto 0..255; XOR with 0x7F
  // does the same while mirroring the X axis.
  // ------------------------------------------------------------------
  logic [7:0]       w_raw;
  logic [POS_W-1:0] w_scaled;
  logic [POS_W:0]   w_diff;
  logic             w_load;

  always_comb begin
    w_raw = w_joy[15:8] + 8'h80;
    case (w_md)
      3'd1:    w_raw = w_joy[7:0] + 8'h80;
      3'd2:    w_raw = w_joy[7:0] ^ 8'h7F;
      3'd3:    w_raw = w_pad;
      default: w_raw = w_joy[15:8] + 8'h80;
    endcase
  end

  generate
    if (POS_W < 8) begin : g_scale_down
      assign w_scaled = w_raw[7 -: POS_W];
    end else if (POS_W > 8) begin : g_scale_up
      assign w_scaled = {w_raw, {(POS_W-8){1'b0}}};
    end else begin : g_scale_eq
      assign w_scaled = w_raw;
    end
  endgenerate

  assign w_diff = (w_scaled >= w_cur) ? ({1'b0, w_scaled} - {1'b0, w_cur})
                                      : ({1'b0, w_cur} - {1'b0, w_scaled});
  assign w_load = (w_diff >= HYST_V);

  // ------------------------------------------------------------------
  // Digital path: accelerating step with saturation at both screen edges.
  // The extra MSB of the sum/difference flags a crossed bound.
  // ------------------------------------------------------------------
  logic [POS_W:0]   w_spd_ext;
  logic [POS_W:0]   w_sub;
  logic [POS_W:0]   w_add;
  logic [3:0]       w_spd_inc;

  assign w_spd_ext = {{(POS_W-3){1'b0}}, w_spd};
  assign w_sub     = {1'b0, w_cur} - w_spd_ext;
  assign w_add     = {1'b0, w_cur} + w_spd_ext;
  assign w_spd_inc = (w_spd >= STEP_MAX_V) ? STEP_MAX_V : (w_spd + 4'd1);

  // ------------------------------------------------------------------
  // Next position / speed for the scanned channel. Any frame spent outside
  // digital mode (including one button pair cancelling out) resets speed.
  // ------------------------------------------------------------------
  logic [POS_W-1:0] w_pos_nxt;
  logic [3:0]       w_spd_nxt;

  always_comb begin
    w_pos_nxt = w_cur;
    w_spd_nxt = 4'd1;
    if (w_md == 3'd4) begin
      if (w_up && !w_dn) begin
        w_pos_nxt = w_sub[POS_W] ? '0 : w_sub[POS_W-1:0];
        w_spd_nxt = w_spd_inc;
      end else if (w_dn && !w_up) begin
        w_pos_nxt = w_add[POS_W] ? '1 : w_add[POS_W-1:0];
        w_spd_nxt = w_spd_inc;
      end
    end else if (w_load) begin
      w_pos_nxt = w_scaled;
    end
  end

  // ------------------------------------------------------------------
  // Scan FSM. r_vblank resets high so a vblank already high at reset
  // release does not count as an edge.
  // ------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ch     <= '0;
      r_vblank <= 1'b1;
      r_strobe <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_pos[k]    <= POS_CTR;
        r_speed[k]  <= 4'd1;
        r_mode_s[k] <= '0;
        r_joy_s[k]  <= '0;
        r_pad_s[k]  <= '0;
        r_up_s[k]   <= 1'b0;
        r_dn_s[k]   <= 1'b0;
      end
    end else begin
      r_vblank <= vblank;
      r_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_vb_rise) begin
            for (int k = 0; k < NUM_CH; k++) begin
              r_mode_s[k] <= mode[3*k +: 3];
              r_joy_s[k]  <= joy_analog[16*k +: 16];
              r_pad_s[k]  <= paddle[8*k +: 8];
              r_up_s[k]   <= btn_up[k];
              r_dn_s[k]   <= btn_down[k];
            end
            r_ch    <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_pos[r_ch]   <= w_pos_nxt;
          r_speed[r_ch] <= w_spd_nxt;
          if (r_ch == CH_LAST) begin
            r_state  <= S_DONE;
            r_strobe <= 1'b1;
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_pos
      assign pos[k*POS_W +: POS_W] = r_pos[k];
    end
  endgenerate

  assign frame_strobe = r_strobe;

endmodule

// File: tb/tb_paddle_input_proc.sv
// Bench for paddle_input_proc: one instance with HYST=0 and one with HYST=4,
// driven from shared stimulus; per-frame expected positions go through queues.
module tb_paddle_input_proc;

  logic        clk = 1'b0;
  logic        reset;
  logic        vblank;
  logic [5:0]  mode;
  logic [31:0] joy;
  logic [15:0] pad;
  logic [1:0]  up;
  logic [1:0]  dn;
  logic [15:0] pos_a;
  logic [15:0] pos_h;
  logic        strobe_a;
  logic        strobe_h;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  logic [15:0] exp_q [$];
  logic [7:0]  exp_h_q [$];

  always #5 clk = ~clk;

  paddle_input_proc #(.NUM_CH(2), .POS_W(8), .STEP_MAX(4), .HYST(0)) dut (
    .clk_sys(clk), .reset(reset), .vblank(vblank), .mode(mode),
    .joy_analog(joy), .paddle(pad), .btn_up(up), .btn_down(dn),
    .pos(pos_a), .frame_strobe(strobe_a));

  paddle_input_proc #(.NUM_CH(2), .POS_W(8), .STEP_MAX(4), .HYST(4)) dut_h (
    .clk_sys(clk), .reset(reset), .vblank(vblank), .mode(mode),
    .joy_analog(joy), .paddle(pad), .btn_up(up), .btn_down(dn),
    .pos(pos_h), .frame_strobe(strobe_h));

  always @(negedge clk) if (strobe_a === 1'b1) strobe_cnt <= strobe_cnt + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] raw_v(input logic [2:0] m, input logic [15:0] j, input logic [7:0] p);
    logic [7:0] v;
    if (m == 3'd1)      v = j[7:0] + 8'h80;
    else if (m == 3'd2) v = 8'hFF - (j[7:0] + 8'h80);
    else if (m == 3'd3) v = p;
    else                v = j[15:8] + 8'h80;
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // One vblank pulse; returns whether frame_strobe came within the bound.
  task automatic do_frame(output bit seen);
    seen = 1'b0;
    @(negedge clk); vblank = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) vblank = 1'b0;
      if (strobe_a === 1'b1) begin seen = 1'b1; break; end
    end
    vblank = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int c0;
    vblank = 1'b1;
    apply_reset();
    checks++; if (pos_a !== 16'h8080) begin errors++; $display("FAIL reset_pos: got %h want 8080", pos_a); end
    checks++; if (pos_h !== 16'h8080) begin errors++; $display("FAIL reset_pos_h: got %h want 8080", pos_h); end
    checks++; if (strobe_a !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", strobe_a); end
    c0 = strobe_cnt;
    repeat (20) @(negedge clk);
    vblank = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (strobe_cnt != c0) begin errors++; $display("FAIL reset_no_strobe: got %0d strobes want 0", strobe_cnt - c0); end
    checks++; if (pos_a !== 16'h8080) begin errors++; $display("FAIL reset_pos_idle: got %h want 8080", pos_a); end
  endtask

  task automatic test_basic();
    apply_reset();
    mode = {3'd2, 3'd0};
    joy  = {16'h0010, 16'h4000};
    up = 2'b00; dn = 2'b00;
    @(negedge clk); vblank = 1'b1;          // cycle t
    @(negedge clk); vblank = 1'b0;          // t+1
    checks++; if (pos_a !== 16'h8080) begin errors++; $display("FAIL basic_t1_pos: got %h want 8080", pos_a); end
    @(negedge clk);                         // t+2
    checks++; if (pos_a !== 16'h80C0) begin errors++; $display("FAIL basic_t2_pos: got %h want 80c0", pos_a); end
    checks++; if (strobe_a !== 1'b0) begin errors++; $display("FAIL basic_t2_strobe: got %b want 0", strobe_a); end
    @(negedge clk);                         // t+3
    checks++; if (pos_a !== 16'h6FC0) begin errors++; $display("FAIL basic_t3_pos: got %h want 6fc0", pos_a); end
    checks++; if (strobe_a !== 1'b1) begin errors++; $display("FAIL basic_t3_strobe: got %b want 1", strobe_a); end
    @(negedge clk);                         // t+4
    checks++; if (strobe_a !== 1'b0) begin errors++; $display("FAIL basic_t4_strobe: got %b want 0", strobe_a); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_digital_up();
    logic [7:0] seq [8] = '{8'h7F, 8'h7D, 8'h7A, 8'h76, 8'h72, 8'h6E, 8'h6E, 8'h6D};
    logic [15:0] e;
    bit seen;
    apply_reset();
    mode = {3'd0, 3'd4};
    joy  = 32'h0000_0000;
    dn   = 2'b00;
    for (int f = 0; f < 8; f++) begin
      up = (f == 6) ? 2'b00 : 2'b01;
      exp_q.push_back({8'h80, seq[f]});
      do_frame(seen);
      checks++; if (!seen) begin errors++; $display("FAIL up_strobe_timeout frame %0d: no strobe within 12 cycles", f); end
      e = exp_q.pop_front();
      checks++; if (pos_a !== e) begin errors++; $display("FAIL up_pos frame %0d: got %h want %h", f, pos_a, e); end
    end
  endtask

  task automatic test_digital_down();
    logic [7:0] seq [7] = '{8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFC};
    logic [15:0] e;
    bit seen;
    apply_reset();
    joy = 32'h0; up = 2'b00; dn = 2'b00;
    pad = 16'hFD00;
    for (int f = 0; f < 7; f++) begin
      mode = (f == 0) ? {3'd3, 3'd4} : {3'd4, 3'd4};
      case (f)
        1, 2, 3: begin up = 2'b00; dn = 2'b10; end
        4:       begin up = 2'b10; dn = 2'b10; end
        5, 6:    begin up = 2'b10; dn = 2'b00; end
        default: begin up = 2'b00; dn = 2'b00; end
      endcase
      exp_q.push_back({seq[f], 8'h80});
      do_frame(seen);
      checks++; if (!seen) begin errors++; $display("FAIL down_strobe_timeout frame %0d: no strobe within 12 cycles", f); end
      e = exp_q.pop_front();
      checks++; if (pos_a !== e) begin errors++; $display("FAIL down_pos frame %0d: got %h want %h", f, pos_a, e); end
    end
    up = 2'b00; dn = 2'b00;
  endtask

  task automatic test_hyst();
    logic [7:0] pin [4] = '{8'h80, 8'h83, 8'h84, 8'h81};
    logic [7:0] ph  [4] = '{8'h80, 8'h80, 8'h84, 8'h84};
    logic [7:0] eh;
    logic [15:0] e;
    bit seen;
    apply_reset();
    mode = {3'd0, 3'd3};
    joy = 32'h0;
    for (int f = 0; f < 4; f++) begin
      pad = {8'h00, pin[f]};
      exp_h_q.push_back(ph[f]);
      exp_q.push_back({8'h80, pin[f]});
      do_frame(seen);
      checks++; if (!seen) begin errors++; $display("FAIL hyst_strobe_timeout frame %0d: no strobe", f); end
      eh = exp_h_q.pop_front();
      checks++; if (pos_h[7:0] !== eh) begin errors++; $display("FAIL hyst_pos frame %0d: got %h want %h", f, pos_h[7:0], eh); end
      e = exp_q.pop_front();
      checks++; if (pos_a !== e) begin errors++; $display("FAIL hyst0_pos frame %0d: got %h want %h", f, pos_a, e); end
    end
  endtask

  task automatic test_random_analog();
    logic [2:0] m0, m1;
    logic [15:0] e;
    int r;
    bit seen;
    apply_reset();
    for (int f = 0; f < 10; f++) begin
      r = $urandom_range(0, 6); m0 = (r >= 4) ? 3'(r + 1) : 3'(r);
      r = $urandom_range(0, 6); m1 = (r >= 4) ? 3'(r + 1) : 3'(r);
      mode = {m1, m0};
      joy  = $urandom;
      pad  = 16'($urandom);
      exp_q.push_back({raw_v(m1, joy[31:16], pad[15:8]), raw_v(m0, joy[15:0], pad[7:0])});
      do_frame(seen);
      checks++; if (!seen) begin errors++; $display("FAIL rand_strobe_timeout frame %0d: no strobe", f); end
      e = exp_q.pop_front();
      checks++; if (pos_a !== e) begin errors++; $display("FAIL rand_pos frame %0d modes %0d/%0d: got %h want %h", f, m0, m1, pos_a, e); end
    end
  endtask

  task automatic test_ignore_edge();
    int c0;
    apply_reset();
    mode = {3'd1, 3'd0};
    joy  = {16'h0010, 16'h4000};
    c0 = strobe_cnt;
    @(negedge clk); vblank = 1'b1;          // t
    @(negedge clk); vblank = 1'b0;          // t+1
    @(negedge clk); vblank = 1'b1;          // t+2: edge lands while scanning
    joy = 32'h0000_0000;
    @(negedge clk);                         // t+3
    checks++; if (strobe_a !== 1'b1) begin errors++; $display("FAIL ignore_strobe_t3: got %b want 1", strobe_a); end
    repeat (10) @(negedge clk);
    vblank = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (strobe_cnt - c0 != 1) begin errors++; $display("FAIL ignore_strobe_count: got %0d want 1", strobe_cnt - c0); end
    checks++; if (pos_a !== 16'h90C0) begin errors++; $display("FAIL ignore_pos: got %h want 90c0", pos_a); end
  endtask

  task automatic test_reset_mid();
    int c0;
    logic [15:0] e;
    bit seen;
    apply_reset();
    mode = {3'd1, 3'd0};
    joy  = {16'h0030, 16'h2000};
    c0 = strobe_cnt;
    @(negedge clk); vblank = 1'b1;          // t
    @(negedge clk); vblank = 1'b0;          // t+1
    @(negedge clk);                         // t+2
    checks++; if (pos_a !== 16'h80A0) begin errors++; $display("FAIL mid_t2_pos: got %h want 80a0", pos_a); end
    reset = 1'b1;
    @(negedge clk);                         // t+3
    checks++; if (pos_a !== 16'h8080) begin errors++; $display("FAIL mid_t3_pos: got %h want 8080", pos_a); end
    checks++; if (strobe_a !== 1'b0) begin errors++; $display("FAIL mid_t3_strobe: got %b want 0", strobe_a); end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (strobe_cnt != c0) begin errors++; $display("FAIL mid_no_strobe: got %0d want 0", strobe_cnt - c0); end
    exp_q.push_back(16'hB0A0);
    do_frame(seen);
    checks++; if (!seen) begin errors++; $display("FAIL mid_after_timeout: no strobe"); end
    e = exp_q.pop_front();
    checks++; if (pos_a !== e) begin errors++; $display("FAIL mid_after_pos: got %h want %h", pos_a, e); end
  endtask

  initial begin
    reset = 1'b1; vblank = 1'b0; mode = '0; joy = '0; pad = '0; up = '0; dn = '0;
    test_reset();
    test_basic();
    test_digital_up();
    test_digital_down();
    test_hyst();
    test_random_analog();
    test_ignore_edge();
    test_reset_mid();
    checks++; if (exp_q.size() != 0 || exp_h_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d/%0d left want 0", exp_q.size(), exp_h_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
